// File: rtl/matrix_input_loader.sv
`default_nettype none
// ============================================================================
// matrix_input_loader : turns parsed entries into row-major matrix_unit writes
// Rev 1.0
// ============================================================================
module matrix_input_loader #(
  parameter int MAX_DIM  = 5,
  parameter int ELEM_MIN = -128,
  parameter int ELEM_MAX = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  req_rows,
  input  logic [2:0]  req_cols,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        abort,
  output logic        mu_clear,
  output logic        mu_set_dims,
  output logic        mu_we,
  output logic [2:0]  mu_dims_r,
  output logic [2:0]  mu_dims_c,
  output logic [2:0]  mu_w_row,
  output logic [2:0]  mu_w_col,
  output logic [7:0]  mu_w_data,
  output logic        busy,
  output logic        done,
  output logic        err_dims,
  output logic        sat_flag,
  output logic [4:0]  count
);

  localparam logic [2:0]         MAX_D = 3'(MAX_DIM);
  localparam logic signed [15:0] EMIN  = 16'(ELEM_MIN);
  localparam logic signed [15:0] EMAX  = 16'(ELEM_MAX);

  typedef enum logic [2:0] {IDLE, DIMS, RECV, FILL, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  rows, cols, row, col;
  logic [2:0]  rows_nx, cols_nx, row_nx, col_nx;
  logic [4:0]  count_nx;
  logic        sat_nx, set_dims_nx, clear_nx, err_nx, done_nx;
  logic [2:0]  dims_r_nx, dims_c_nx;
  logic        wr;
  logic [7:0]  wr_val;
  logic signed [15:0] din;
  logic [7:0]  clamp_val;
  logic        clamp_sat;
  logic        dims_ok, at_last, beat;

  assign din     = in_data;
  assign dims_ok = (req_rows != 3'd0) && (req_rows <= MAX_D) &&
                   (req_cols != 3'd0) && (req_cols <= MAX_D);
  assign at_last = (row == rows - 3'd1) && (col == cols - 3'd1);
  // in_ready is registered as "state is RECV", so it doubles as the state qualifier
  assign beat    = in_valid && in_ready;

  always_comb begin
    clamp_val = din[7:0];
    clamp_sat = 1'b0;
    if (din > EMAX) begin
      clamp_val = EMAX[7:0];
      clamp_sat = 1'b1;
    end else if (din < EMIN) begin
      clamp_val = EMIN[7:0];
      clamp_sat = 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    rows_nx     = rows;
    cols_nx     = cols;
    row_nx      = row;
    col_nx      = col;
    count_nx    = count;
    sat_nx      = sat_flag;
    set_dims_nx = 1'b0;
    dims_r_nx   = '0;
    dims_c_nx   = '0;
    clear_nx    = 1'b0;
    err_nx      = 1'b0;
    done_nx     = 1'b0;
    wr          = 1'b0;
    wr_val      = '0;
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      clear_nx = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !busy) begin
            if (dims_ok) begin
              state_nx    = DIMS;
              rows_nx     = req_rows;
              cols_nx     = req_cols;
              row_nx      = '0;
              col_nx      = '0;
              count_nx    = '0;
              sat_nx      = 1'b0;
              set_dims_nx = 1'b1;
              dims_r_nx   = req_rows;
              dims_c_nx   = req_cols;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        DIMS: state_nx = RECV;
        RECV: begin
          if (beat) begin
            wr     = 1'b1;
            wr_val = clamp_val;
            if (clamp_sat) sat_nx = 1'b1;
          end
          if (beat && at_last)   state_nx = DONE;
          else if (in_last)      state_nx = FILL;
        end
        FILL: begin
          wr = 1'b1;
          if (at_last) state_nx = DONE;
        end
        DONE: begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
    if (wr) begin
      count_nx = count + 5'd1;
      if (col == cols - 3'd1) begin
        col_nx = '0;
        row_nx = row + 3'd1;
      end else begin
        col_nx = col + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rows        <= '0;
      cols        <= '0;
      row         <= '0;
      col         <= '0;
      count       <= '0;
      sat_flag    <= 1'b0;
      in_ready    <= 1'b0;
      mu_clear    <= 1'b0;
      mu_set_dims <= 1'b0;
      mu_dims_r   <= '0;
      mu_dims_c   <= '0;
      mu_we       <= 1'b0;
      mu_w_row    <= '0;
      mu_w_col    <= '0;
      mu_w_data   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_dims    <= 1'b0;
    end else begin
      state       <= state_nx;
      rows        <= rows_nx;
      cols        <= cols_nx;
      row         <= row_nx;
      col         <= col_nx;
      count       <= count_nx;
      sat_flag    <= sat_nx;
      in_ready    <= (state_nx == RECV);
      mu_clear    <= clear_nx;
      mu_set_dims <= set_dims_nx;
      mu_dims_r   <= dims_r_nx;
      mu_dims_c   <= dims_c_nx;
      mu_we       <= wr;
      mu_w_row    <= wr ? row : 3'd0;
      mu_w_col    <= wr ? col : 3'd0;
      mu_w_data   <= wr_val;
      // the done cycle still counts as busy so a start there is ignored
      busy        <= (state_nx != IDLE) || done_nx;
      done        <= done_nx;
      err_dims    <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_input_loader.sv
`default_nettype none
// ============================================================================
// tb_matrix_input_loader : vector table plus scoreboarded write checking
// Rev 1.0
// ============================================================================
module tb_matrix_input_loader;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  req_rows = '0, req_cols = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, abort = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, mu_clear, mu_set_dims, mu_we, busy, done, err_dims, sat_flag;
  logic [2:0]  mu_dims_r, mu_dims_c, mu_w_row, mu_w_col;
  logic [7:0]  mu_w_data;
  logic [4:0]  count;
  logic [32:0] all_out;

  matrix_input_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_rows(req_rows), .req_cols(req_cols),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .abort(abort), .mu_clear(mu_clear), .mu_set_dims(mu_set_dims), .mu_we(mu_we),
    .mu_dims_r(mu_dims_r), .mu_dims_c(mu_dims_c), .mu_w_row(mu_w_row), .mu_w_col(mu_w_col),
    .mu_w_data(mu_w_data), .busy(busy), .done(done), .err_dims(err_dims),
    .sat_flag(sat_flag), .count(count)
  );

  assign all_out = {in_ready, mu_clear, mu_set_dims, mu_we, mu_dims_r, mu_dims_c,
                    mu_w_row, mu_w_col, mu_w_data, busy, done, err_dims, sat_flag, count};

  always #5 clk = ~clk;

  typedef struct packed {logic [2:0] r; logic [2:0] c; logic [7:0] d;} wr_t;
  typedef struct {logic [2:0] r; logic [2:0] c; int d; logic err; logic [7:0] e; logic sat;} vec_t;

  wr_t        sbq[$];
  int         checks = 0, errors = 0, cyc = 0, last_we_cyc = -100;
  logic [2:0] mrow, mcol, mcols;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write the DUT issues must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && mu_we) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected write: got r%0d c%0d d%0h expected none",
                 mu_w_row, mu_w_col, mu_w_data);
      end else begin
        check("write r/c/data", {mu_w_row, mu_w_col, mu_w_data}, sbq.pop_front());
      end
      last_we_cyc = cyc;
    end
  end

  task automatic push_write(input logic [7:0] d);
    sbq.push_back({mrow, mcol, d});
    if (mcol == mcols - 3'd1) begin
      mcol = '0;
      mrow = mrow + 3'd1;
    end else begin
      mcol = mcol + 3'd1;
    end
  endtask

  task automatic start_load(input logic [2:0] r, input logic [2:0] c);
    req_rows = r; req_cols = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("set_dims cycle", {mu_set_dims, mu_dims_r, mu_dims_c, busy, in_ready},
          {1'b1, r, c, 1'b1, 1'b0});
    check("start clears sat/count", {sat_flag, count}, 0);
    @(negedge clk);
    check("in_ready rises", {in_ready, mu_set_dims}, 2'b10);
    mcols = c; mrow = '0; mcol = '0;
  endtask

  task automatic send_beat(input int d, input int e, input logic last);
    in_valid = 1'b1; in_data = d[15:0]; in_last = last;
    push_write(e[7:0]);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output int waited);
    waited = 0;
    while (done !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("done seen", done, 1);
    check("done one cycle after last write", 64'(cyc - last_we_cyc), 1);
    check("busy during done", busy, 1);
    @(negedge clk);
    check("idle after done", {busy, done}, 0);
    check("scoreboard drained", sbq.size(), 0);
  endtask

  vec_t tv[14];
  int   w, nb;

  initial begin
    tv[0]  = '{3'd1, 3'd1, 0,      1'b0, 8'h00, 1'b0};
    tv[1]  = '{3'd1, 3'd1, 127,    1'b0, 8'h7F, 1'b0};
    tv[2]  = '{3'd1, 3'd1, 128,    1'b0, 8'h7F, 1'b1};
    tv[3]  = '{3'd1, 3'd1, -128,   1'b0, 8'h80, 1'b0};
    tv[4]  = '{3'd1, 3'd1, -129,   1'b0, 8'h80, 1'b1};
    tv[5]  = '{3'd1, 3'd1, 32767,  1'b0, 8'h7F, 1'b1};
    tv[6]  = '{3'd1, 3'd1, -32768, 1'b0, 8'h80, 1'b1};
    tv[7]  = '{3'd5, 3'd5, -1,     1'b0, 8'hFF, 1'b0};
    tv[8]  = '{3'd5, 3'd1, 100,    1'b0, 8'h64, 1'b0};
    tv[9]  = '{3'd0, 3'd3, 1,      1'b1, 8'h00, 1'b0};
    tv[10] = '{3'd6, 3'd2, 1,      1'b1, 8'h00, 1'b0};
    tv[11] = '{3'd3, 3'd0, 1,      1'b1, 8'h00, 1'b0};
    tv[12] = '{3'd1, 3'd7, 1,      1'b1, 8'h00, 1'b0};
    tv[13] = '{3'd5, 3'd6, 1,      1'b1, 8'h00, 1'b0};

    @(negedge clk);
    check("reset outputs", all_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort in idle ignored", {mu_clear, busy}, 0);

    for (int i = 0; i < 14; i++) begin
      if (tv[i].err) begin
        req_rows = tv[i].r; req_cols = tv[i].c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_dims pulse", {err_dims, busy, mu_set_dims}, 3'b100);
        @(negedge clk);
        check("err_dims clears", {err_dims, busy, mu_set_dims, in_ready}, 0);
      end else begin
        nb = int'(tv[i].r) * int'(tv[i].c);
        start_load(tv[i].r, tv[i].c);
        for (int k = 0; k < nb; k++) send_beat(tv[i].d, int'(tv[i].e), 1'b0);
        wait_done(w);
        check("vector done latency", w, 1);
        check("vector count", count, nb);
        check("vector sat", sat_flag, tv[i].sat);
      end
    end

    // 2x3 continuous load
    start_load(3'd2, 3'd3);
    send_beat(10, 10, 1'b0); send_beat(20, 20, 1'b0); send_beat(30, 30, 1'b0);
    send_beat(-5, 251, 1'b0); send_beat(-6, 250, 1'b0); send_beat(-7, 249, 1'b0);
    wait_done(w);
    check("2x3 done latency", w, 1);
    check("2x3 count/sat", {count, sat_flag}, {5'd6, 1'b0});

    // 2x2 early end, zero-filled
    start_load(3'd2, 3'd2);
    send_beat(4, 4, 1'b0);
    send_beat(5, 5, 1'b1);
    push_write(8'h00); push_write(8'h00);
    check("fill drops in_ready", in_ready, 0);
    wait_done(w);
    check("fill done latency", w, 3);
    check("fill count", count, 4);

    // 1x3 saturating load, then sat cleared by next start
    start_load(3'd1, 3'd3);
    send_beat(300, 127, 1'b0);
    check("sat after first write", sat_flag, 1);
    send_beat(-200, 128, 1'b0);
    send_beat(7, 7, 1'b0);
    wait_done(w);
    check("sat sticky", {count, sat_flag}, {5'd3, 1'b1});
    start_load(3'd1, 3'd1);
    send_beat(1, 1, 1'b0);
    wait_done(w);

    // 3x3 abort after 4 beats
    start_load(3'd3, 3'd3);
    for (int k = 0; k < 4; k++) send_beat(k + 1, k + 1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort clear pulse", {mu_clear, busy, done, in_ready, mu_we}, 5'b10000);
    check("abort count", count, 4);
    @(negedge clk);
    check("abort no done", {mu_clear, done, busy}, 0);
    check("abort drained", sbq.size(), 0);

    // asynchronous reset mid-RECV
    start_load(3'd3, 3'd3);
    send_beat(1, 1, 1'b0); send_beat(2, 2, 1'b0);
    in_valid = 1'b1; in_data = 16'd9;
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", all_out, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset drained", sbq.size(), 0);
    @(negedge clk);

    // 2x2 with gapped beats and a start pulse during RECV
    start_load(3'd2, 3'd2);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 16'(k + 1);
      push_write(8'(k + 1));
      @(negedge clk);
      in_valid = 1'b0;
      check("write after beat", mu_we, 1);
      if (k < 3) begin
        if (k == 1) begin
          start = 1'b1; req_rows = 3'd1; req_cols = 3'd1;
        end
        @(negedge clk);
        start = 1'b0;
        check("gap has no write", {mu_we, mu_set_dims, err_dims}, 0);
      end
    end
    wait_done(w);
    check("gapped done latency", w, 1);
    check("gapped count", count, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
